// File: rtl/button_scan_ctrl.sv
// Debounce scheduler: NB_BUTTONS inputs share one settle timer through a round-robin grant.
// Define BUTTON_SCAN_IRQ_EN to add sticky event flags with irq_clr/irq ports.
module button_scan_ctrl #(
  parameter int NB_BUTTONS  = 4,
  parameter int CLK_FREQ    = 95000,
  parameter int DEBOUNCE_MS = 20,
  localparam int OW         = (NB_BUTTONS > 1) ? $clog2(NB_BUTTONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_BUTTONS-1:0] button_in,
  output logic [NB_BUTTONS-1:0] button_state,
  output logic [NB_BUTTONS-1:0] button_event,
  output logic                  busy,
  output logic [OW-1:0]         owner
`ifdef BUTTON_SCAN_IRQ_EN
  ,
  input  logic [NB_BUTTONS-1:0] irq_clr,
  output logic                  irq
`endif
);

  localparam int MAX_COUNT = CLK_FREQ * DEBOUNCE_MS;
  localparam int TW        = $clog2(MAX_COUNT + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;

  state_t                  state;
  logic [NB_BUTTONS-1:0]   sync1;
  logic [NB_BUTTONS-1:0]   sync2;
  logic [NB_BUTTONS-1:0]   req;
  logic [NB_BUTTONS-1:0]   commit_set;
  logic [TW-1:0]           timer;
  logic [OW-1:0]           last_grant;
  logic [OW-1:0]           grant_idx;
  logic                    grant_valid;

  assign req = sync2 ^ button_state;

  // Descending scan so the lowest offset from last_grant+1 is the one that sticks.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NB_BUTTONS; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NB_BUTTONS]) begin
        grant_valid = 1'b1;
        grant_idx   = OW'((int'(last_grant) + k) % NB_BUTTONS);
      end
    end
  end

  always_comb begin
    commit_set = '0;
    if (state == COMMIT && req[owner]) commit_set[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1        <= '0;
      sync2        <= '0;
      button_state <= '0;
      button_event <= '0;
      busy         <= 1'b0;
      owner        <= '0;
      timer        <= '0;
      last_grant   <= OW'(NB_BUTTONS - 1);
      state        <= IDLE;
    end else begin
      sync1        <= button_in;
      sync2        <= sync1;
      button_event <= commit_set;
      button_state <= button_state ^ commit_set;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_idx;
            last_grant <= grant_idx;
            timer      <= '0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (!req[owner]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == TW'(MAX_COUNT - 1)) begin
            state <= COMMIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUTTON_SCAN_IRQ_EN
  logic [NB_BUTTONS-1:0] event_flags;

  // A new event outranks a clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      event_flags <= '0;
      irq         <= 1'b0;
    end else begin
      event_flags <= (event_flags & ~irq_clr) | commit_set;
      irq         <= |event_flags;
    end
  end
`endif

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Scoreboard bench for button_scan_ctrl with MAX_COUNT = 8 (CLK_FREQ=1, DEBOUNCE_MS=8).
module tb_button_scan_ctrl;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] button_in = '0;
  logic [NB-1:0] button_state;
  logic [NB-1:0] button_event;
  logic          busy;
  logic [1:0]    owner;
`ifdef BUTTON_SCAN_IRQ_EN
  logic [NB-1:0] irq_clr = '0;
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   idx;
    int   cyc;
    logic level;
  } exp_t;
  exp_t sb[$];

  button_scan_ctrl #(.NB_BUTTONS(NB), .CLK_FREQ(1), .DEBOUNCE_MS(8)) dut (
    .clk(clk),
    .rst(rst),
    .button_in(button_in),
    .button_state(button_state),
    .button_event(button_event),
    .busy(busy),
    .owner(owner)
`ifdef BUTTON_SCAN_IRQ_EN
    ,
    .irq_clr(irq_clr),
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every event pulse must match the oldest pending expectation in index, cycle and level.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [NB-1:0] want;
    if (rst === 1'b1 && button_event !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event cyc=%0d got %b expected none", cyc, button_event);
      end else begin
        e = sb.pop_front();
        want = '0;
        want[e.idx] = 1'b1;
        if (button_event !== want || cyc !== e.cyc || button_state[e.idx] !== e.level) begin
          errors++;
          $display("[TB] FAIL event got ev=%b cyc=%0d lvl=%b expected ev=%b cyc=%0d lvl=%b",
                   button_event, cyc, button_state[e.idx], want, e.cyc, e.level);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d expected completion", cyc);
    $fatal(1, "[TB] timeout");
  end

  task automatic goto_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycle(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset();
    button_in = '0;
`ifdef BUTTON_SCAN_IRQ_EN
    irq_clr = '0;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic push_exp(input int idx, input int c, input logic level);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    e.level = level;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (button_state !== '0 || button_event !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
        errors++;
        $display("[TB] FAIL reset_idle got st=%b ev=%b busy=%b own=%0d expected 0,0,0,0",
                 button_state, button_event, busy, owner);
      end
    end
    #1;
  endtask

  task automatic test_single_press();
    int c;
    do_reset();
    c = cyc;
    button_in[1] = 1'b1;
    push_exp(1, c + 12, 1'b1);
    wait_cycle(c + 3);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd1) begin
      errors++;
      $display("[TB] FAIL press_grant got busy=%b own=%0d expected 1,1", busy, owner);
    end
    wait_drain("press", 40);
    checks++;
    if (button_state !== 4'b0010 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL press_state got st=%b busy=%b expected 0010,0", button_state, busy);
    end
  endtask

  task automatic test_bounce();
    int c;
    do_reset();
    c = cyc;
    button_in[2] = 1'b1;
    goto_edge(c + 5);
    button_in[2] = 1'b0;
    wait_cycle(c + 7);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd2) begin
      errors++;
      $display("[TB] FAIL bounce_busy got busy=%b own=%0d expected 1,2", busy, owner);
    end
    wait_cycle(c + 8);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_abort got busy=%b expected 0", busy);
    end
    wait_drain("bounce", 20);
    checks++;
    if (button_state !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL bounce_state got %b expected 0000", button_state);
    end
  endtask

  task automatic test_round_robin();
    int c;
    do_reset();
    c = cyc;
    button_in = 4'b1001;
    push_exp(0, c + 12, 1'b1);
    push_exp(3, c + 22, 1'b1);
    wait_cycle(c + 3);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("[TB] FAIL rr_first got busy=%b own=%0d expected 1,0", busy, owner);
    end
    wait_cycle(c + 13);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd3) begin
      errors++;
      $display("[TB] FAIL rr_second got busy=%b own=%0d expected 1,3", busy, owner);
    end
    wait_drain("rr_rise", 40);
    // last_grant is now 3, so the next scan wraps to 0 first.
    c = cyc;
    button_in = 4'b0000;
    push_exp(0, c + 12, 1'b0);
    push_exp(3, c + 22, 1'b0);
    wait_cycle(c + 3);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("[TB] FAIL rr_wrap got busy=%b own=%0d expected 1,0", busy, owner);
    end
    wait_drain("rr_fall", 40);
    checks++;
    if (button_state !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rr_state got %b expected 0000", button_state);
    end
  endtask

  task automatic test_reset_mid_settle();
    int c;
    do_reset();
    c = cyc;
    button_in[1] = 1'b1;
    goto_edge(c + 7);
    rst = 1'b0;
    wait_cycle(c + 8);
    checks++;
    if (busy !== 1'b0 || button_state !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset got busy=%b st=%b expected 0,0000", busy, button_state);
    end
    rst = 1'b1;
    push_exp(1, c + 20, 1'b1);
    wait_cycle(c + 10);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_resync got busy=%b expected 0", busy);
    end
    wait_cycle(c + 11);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd1) begin
      errors++;
      $display("[TB] FAIL midreset_regrant got busy=%b own=%0d expected 1,1", busy, owner);
    end
    wait_drain("midreset", 40);
  endtask

`ifdef BUTTON_SCAN_IRQ_EN
  task automatic test_irq();
    int c;
    int d;
    do_reset();
    c = cyc;
    button_in[1] = 1'b1;
    push_exp(1, c + 12, 1'b1);
    wait_cycle(c + 12);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_early got %b expected 0", irq);
    end
    wait_cycle(c + 13);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_set got %b expected 1", irq);
    end
    goto_edge(c + 14);
    irq_clr = 4'b0010;
    goto_edge(c + 15);
    irq_clr = 4'b0000;
    wait_cycle(c + 16);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_clear got %b expected 0", irq);
    end
    goto_edge(c + 17);
    d = cyc;
    button_in[1] = 1'b0;
    push_exp(1, d + 12, 1'b0);
    goto_edge(d + 11);
    irq_clr = 4'b0010;
    goto_edge(d + 12);
    irq_clr = 4'b0000;
    wait_cycle(d + 14);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_set_wins got %b expected 1", irq);
    end
    wait_drain("irq", 20);
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_reset_mid_settle();
`ifdef BUTTON_SCAN_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
